// File: rtl/gpu_draw_line_stream.sv
// Streaming Bresenham line rasteriser: latches two endpoints and a colour on start,
// then walks the line one pixel per cycle onto a valid/ready stream with optional clipping.
module gpu_draw_line_stream #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 9,
  parameter int COLOR_BITS  = 24,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int CLIP_EN     = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_BITS-1:0]  x1,
  input  logic [HEIGHT_BITS-1:0] y1,
  input  logic [WIDTH_BITS-1:0]  x2,
  input  logic [HEIGHT_BITS-1:0] y2,
  input  logic [COLOR_BITS-1:0]  color_i,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   px_valid,
  input  logic                   px_ready,
  output logic [WIDTH_BITS-1:0]  px_x,
  output logic [HEIGHT_BITS-1:0] px_y,
  output logic [COLOR_BITS-1:0]  px_color,
  output logic                   px_last
);

  localparam int MAX_BITS = (WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS;
  localparam int CW       = MAX_BITS + 2;

  localparam logic [WIDTH_BITS:0]  SCR_W   = (WIDTH_BITS+1)'(SCREEN_W);
  localparam logic [HEIGHT_BITS:0] SCR_H   = (HEIGHT_BITS+1)'(SCREEN_H);
  localparam bit                   CLIP_ON = (CLIP_EN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    FIN  = 2'd2
  } state_e;

  typedef logic signed [CW-1:0] err_t;

  state_e                   state_q, state_d;
  logic [WIDTH_BITS-1:0]    cur_x_q, cur_x_d;
  logic [HEIGHT_BITS-1:0]   cur_y_q, cur_y_d;
  logic [WIDTH_BITS-1:0]    end_x_q, end_x_d;
  logic [HEIGHT_BITS-1:0]   end_y_q, end_y_d;
  logic [COLOR_BITS-1:0]    color_q, color_d;
  err_t                     dx_q, dx_d;
  err_t                     dy_q, dy_d;
  err_t                     err_q, err_d;
  logic                     sx_q, sx_d;
  logic                     sy_q, sy_d;

  logic [WIDTH_BITS-1:0]    abs_dx;
  logic [HEIGHT_BITS-1:0]   abs_dy;
  err_t                     dx_init;
  err_t                     dy_init;

  assign abs_dx  = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
  assign abs_dy  = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
  assign dx_init = $signed({{(CW-WIDTH_BITS){1'b0}}, abs_dx});
  assign dy_init = -$signed({{(CW-HEIGHT_BITS){1'b0}}, abs_dy});

  // err can drift up to ~1.5x the major delta, so doubling it needs one bit beyond err.
  logic signed [CW:0] e2;
  logic signed [CW:0] dx_ext;
  logic signed [CW:0] dy_ext;
  logic               step_x;
  logic               step_y;

  assign e2     = $signed({err_q, 1'b0});
  assign dx_ext = {dx_q[CW-1], dx_q};
  assign dy_ext = {dy_q[CW-1], dy_q};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);

  logic at_end;
  logic on_screen;
  logic visible;

  assign at_end    = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign on_screen = ({1'b0, cur_x_q} < SCR_W) && ({1'b0, cur_y_q} < SCR_H);
  assign visible   = !CLIP_ON || on_screen;

  assign px_x     = cur_x_q;
  assign px_y     = cur_y_q;
  assign px_color = color_q;

  always_comb begin
    // NOTE: every _d and output takes its hold/idle value first, so no path infers a latch.
    state_d  = state_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    color_d  = color_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    busy     = 1'b0;
    done     = 1'b0;
    px_valid = 1'b0;
    px_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_x_d = x1;
          cur_y_d = y1;
          end_x_d = x2;
          end_y_d = y2;
          color_d = color_i;
          dx_d    = dx_init;
          dy_d    = dy_init;
          err_d   = dx_init + dy_init;
          sx_d    = (x1 < x2);
          sy_d    = (y1 < y2);
          state_d = STEP;
        end
      end

      STEP: begin
        busy     = 1'b1;
        px_valid = visible;
        px_last  = visible && at_end;
        // Abort outranks the handshake: the presented pixel is treated as undelivered.
        if (abort) begin
          state_d = IDLE;
        end else if (!visible || px_ready) begin
          if (at_end) begin
            state_d = FIN;
          end else begin
            err_d = err_q + (step_x ? dy_q : err_t'(0)) + (step_y ? dx_q : err_t'(0));
            if (step_x) cur_x_d = sx_q ? (cur_x_q + WIDTH_BITS'(1))  : (cur_x_q - WIDTH_BITS'(1));
            if (step_y) cur_y_d = sy_q ? (cur_y_q + HEIGHT_BITS'(1)) : (cur_y_q - HEIGHT_BITS'(1));
          end
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      end_x_q <= '0;
      end_y_q <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      end_x_q <= end_x_d;
      end_y_q <= end_y_d;
      color_q <= color_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

endmodule

// File: tb/tb_gpu_draw_line_stream.sv
// Bench for gpu_draw_line_stream: a clipped and an unclipped instance share stimulus and
// are compared against a point-list model of the line built from plain integer arithmetic.
module tb_gpu_draw_line_stream;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 24;
  localparam int SW = 640;
  localparam int SH = 480;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic [WB-1:0] x1, x2;
  logic [HB-1:0] y1, y2;
  logic [CB-1:0] color_i;
  logic          start, abort, px_ready;

  logic          busy_w     [2];
  logic          done_w     [2];
  logic          px_valid_w [2];
  logic          px_last_w  [2];
  logic [WB-1:0] px_x_w     [2];
  logic [HB-1:0] px_y_w     [2];
  logic [CB-1:0] px_color_w [2];

  gpu_draw_line_stream #(.CLIP_EN(1)) u_clip (
    .clk(clk), .rst(rst), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .color_i(color_i),
    .start(start), .abort(abort), .busy(busy_w[0]), .done(done_w[0]),
    .px_valid(px_valid_w[0]), .px_ready(px_ready), .px_x(px_x_w[0]), .px_y(px_y_w[0]),
    .px_color(px_color_w[0]), .px_last(px_last_w[0])
  );

  gpu_draw_line_stream #(.CLIP_EN(0)) u_noclip (
    .clk(clk), .rst(rst), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .color_i(color_i),
    .start(start), .abort(abort), .busy(busy_w[1]), .done(done_w[1]),
    .px_valid(px_valid_w[1]), .px_ready(px_ready), .px_x(px_x_w[1]), .px_y(px_y_w[1]),
    .px_color(px_color_w[1]), .px_last(px_last_w[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  pix_t exp_q0[$];
  pix_t exp_q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs(input int k);
    return 64'({busy_w[k], done_w[k], px_valid_w[k], px_last_w[k],
                px_x_w[k], px_y_w[k], px_color_w[k]});
  endfunction

  function automatic pix_t get_exp(input int k, input int i);
    return (k == 0) ? exp_q0[i] : exp_q1[i];
  endfunction

  function automatic int exp_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Reference: enumerate every point of the line, then keep the on-screen ones for the clipped view.
  task automatic build_model(input int ax1, input int ay1, input int ax2, input int ay2,
                             output int nwalk);
    int   dx, dy, sx, sy, err, e2, x, y;
    pix_t p;
    exp_q0.delete();
    exp_q1.delete();
    dx  = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
    dy  = -((ay2 > ay1) ? ay2 - ay1 : ay1 - ay2);
    sx  = (ax1 < ax2) ? 1 : -1;
    sy  = (ay1 < ay2) ? 1 : -1;
    err = dx + dy;
    x   = ax1;
    y   = ay1;
    nwalk = 0;
    while (nwalk < 4096) begin
      p.x    = x;
      p.y    = y;
      p.last = (x == ax2) && (y == ay2);
      nwalk++;
      exp_q1.push_back(p);
      if (x < SW && y < SH) exp_q0.push_back(p);
      if (p.last) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                          input logic [CB-1:0] col, input int ready_pct,
                          input int stall_lo, input int stall_hi, input int abort_at,
                          input bit start_abort, input bit busy_starts);
    int          nwalk, cnt;
    int          idx[2], stalls[2];
    bit          fin[2], held[2];
    logic [63:0] hold_v[2];
    bit          rdy, ab, allow, aborted;
    string       pfx;
    pix_t        e;

    build_model(ax1, ay1, ax2, ay2, nwalk);
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; stalls[k] = 0; fin[k] = 1'b0; held[k] = 1'b0; hold_v[k] = '0;
    end

    @(negedge clk);
    x1 = WB'(ax1); y1 = HB'(ay1); x2 = WB'(ax2); y2 = HB'(ay2);
    color_i = col; start = 1'b1; abort = start_abort; px_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cnt = 1;
    aborted = 1'b0;

    while (!(fin[0] && fin[1]) && cnt < BUDGET) begin
      rdy   = ($urandom_range(99) < ready_pct) && !(cnt >= stall_lo && cnt <= stall_hi);
      ab    = (cnt == abort_at);
      allow = !fin[0] && !fin[1];
      px_ready = rdy;
      abort    = ab;
      x1 = WB'($urandom); y1 = HB'($urandom); x2 = WB'($urandom); y2 = HB'($urandom);
      color_i = CB'($urandom);
      start = busy_starts && allow && ($urandom_range(3) == 0);

      for (int k = 0; k < 2; k++) begin
        pfx = (k == 0) ? "clip" : "noclip";
        if (fin[k]) continue;
        if (done_w[k]) begin
          check({pfx, "_done_cycle"}, 64'(cnt), 64'(nwalk + stalls[k] + 1));
          check({pfx, "_pixel_count"}, 64'(idx[k]), 64'(exp_size(k)));
          check({pfx, "_busy_in_fin"}, 64'(busy_w[k]), 64'(0));
          fin[k] = 1'b1;
          continue;
        end
        check({pfx, "_busy"}, 64'(busy_w[k]), 64'(1));
        if (held[k]) check({pfx, "_stall_hold"}, outs(k), hold_v[k]);
        held[k] = 1'b0;
        if (px_valid_w[k] && !ab) begin
          if (rdy) begin
            if (idx[k] < exp_size(k)) begin
              e = get_exp(k, idx[k]);
              check({pfx, "_px_x"},     64'(px_x_w[k]),     64'(e.x));
              check({pfx, "_px_y"},     64'(px_y_w[k]),     64'(e.y));
              check({pfx, "_px_last"},  64'(px_last_w[k]),  64'(e.last));
              check({pfx, "_px_color"}, 64'(px_color_w[k]), 64'(col));
            end else begin
              check({pfx, "_extra_pixel"}, 64'(idx[k]), 64'(exp_size(k)));
            end
            idx[k]++;
          end else begin
            stalls[k]++;
            held[k]   = 1'b1;
            hold_v[k] = outs(k);
          end
        end
      end

      if (ab) begin
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      cnt++;
    end

    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0;
      for (int k = 0; k < 2; k++) begin
        pfx = (k == 0) ? "clip" : "noclip";
        check({pfx, "_abort_valid"}, 64'(px_valid_w[k]), 64'(0));
        check({pfx, "_abort_busy"},  64'(busy_w[k]),     64'(0));
        check({pfx, "_abort_done"},  64'(done_w[k]),     64'(0));
        check({pfx, "_abort_count"}, 64'(idx[k]),        64'(abort_at - 1));
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) check("abort_no_late_done", 64'(done_w[k]), 64'(0));
    end else if (!(fin[0] && fin[1])) begin
      check("timeout_waiting_done", 64'(0), 64'(1));
    end
    abort    = 1'b0;
    px_ready = 1'b1;
  endtask

  task automatic reset_mid_line();
    @(negedge clk);
    x1 = WB'(0); y1 = HB'(0); x2 = WB'(50); y2 = HB'(20);
    color_i = 24'h00FF00; start = 1'b1; px_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check("reset_mid_line_outputs", outs(k), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("after_reset_idle", outs(k), 64'(0));
  endtask

  initial begin
    int ax1, ay1, ax2, ay2;
    rst = 1'b1;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0; color_i = '0;
    start = 1'b0; abort = 1'b0; px_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) check("reset_outputs", outs(k), 64'(0));
    rst = 1'b0;

    run_line(0, 0, 3, 0, 24'hFF0000, 100, -1, -1, -1, 1'b0, 1'b0);
    run_line(2, 5, 0, 0, 24'h123456, 100, -1, -1, -1, 1'b0, 1'b0);
    run_line(0, 0, 2, 5, 24'hABCDEF, 100, -1, -1, -1, 1'b0, 1'b0);
    run_line(0, 0, 2, 5, 24'h0F0F0F, 100,  2,  4, -1, 1'b0, 1'b0);
    run_line(637, 10, 642, 10, 24'h00AA55, 100, -1, -1, -1, 1'b0, 1'b0);
    run_line(5, 5, 5, 5, 24'h777777, 100, -1, -1, -1, 1'b0, 1'b0);
    run_line(0, 0, 60, 17, 24'h314159, 100, -1, -1, -1, 1'b0, 1'b1);
    run_line(0, 0, 9, 0, 24'hDEAD00, 100, -1, -1, 3, 1'b0, 1'b0);
    run_line(1, 1, 4, 2, 24'h00BEEF, 100, -1, -1, -1, 1'b1, 1'b0);
    run_line(700, 500, 710, 505, 24'h999999, 100, -1, -1, -1, 1'b0, 1'b0);
    reset_mid_line();
    run_line(3, 7, 11, 2, 24'h246801, 100, -1, -1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ax1 = $urandom_range(720, 560); ax2 = $urandom_range(720, 560);
      ay1 = $urandom_range(511, 400); ay2 = $urandom_range(511, 400);
      run_line(ax1, ay1, ax2, ay2, CB'($urandom), $urandom_range(100, 40),
               -1, -1, -1, 1'b0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
